// File: rtl/neuron_backprop_update.sv
// neuron_backprop_update: serial weight/bias update and error back-propagation for one neuron,
// one element per clock through a shared pair of multipliers.
module neuron_backprop_update #(
  parameter int N        = 10,
  parameter int DW       = 8,
  parameter int LR_SHIFT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW*N-1:0] inp,
  input  logic [DW*N-1:0] w,
  input  logic [DW-1:0]   bias,
  input  logic [DW-1:0]   delta,
  output logic            busy,
  output logic            done,
  output logic [DW*N-1:0] w_new,
  output logic [DW-1:0]   bias_new,
  output logic [DW*N-1:0] err_out
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*DW;
  localparam int SW = 2*DW+1;
  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic signed [SW-1:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UPDATE, BIAS} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic signed [DW-1:0] ci [N];
  logic signed [DW-1:0] cw [N];
  logic signed [DW-1:0] cb, cd;
  logic signed [DW-1:0] ei, ew;
  logic signed [PW-1:0] pi, pw;
  logic signed [SW-1:0] wf, ef, bf;

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] x);
    return (x > MAXV) ? MAXV[DW-1:0] : (x < MINV) ? MINV[DW-1:0] : x[DW-1:0];
  endfunction

  // Datapath works only on captured operands, so external feedback of w_new into w is safe
  always_comb begin
    ei = ci[idx];
    ew = cw[idx];
    pi = PW'(ei) * PW'(cd);
    pw = PW'(ew) * PW'(cd);
    wf = SW'(ew) - (SW'(pi) >>> (7+LR_SHIFT));
    ef = SW'(pw) >>> 7;
    bf = SW'(cb) - (SW'(cd) >>> LR_SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      w_new    <= '0;
      bias_new <= '0;
      err_out  <= '0;
      cb       <= '0;
      cd       <= '0;
      for (int i = 0; i < N; i++) begin
        ci[i] <= '0;
        cw[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < N; i++) begin
              ci[i] <= inp[DW*i +: DW];
              cw[i] <= w[DW*i +: DW];
            end
            cb    <= bias;
            cd    <= delta;
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          w_new[DW*int'(idx) +: DW]   <= sat(wf);
          err_out[DW*int'(idx) +: DW] <= sat(ef);
          if (idx == LAST) state <= BIAS;
          else idx <= idx + 1'b1;
        end
        BIAS: begin
          bias_new <= sat(bf);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_backprop_update.sv
// tb_neuron_backprop_update: randomized scoreboard bench for the backprop update block.
module tb_neuron_backprop_update;
  localparam int N  = 10;
  localparam int DW = 8;
  localparam int LR = 3;

  typedef struct {
    logic [DW*N-1:0] wn;
    logic [DW*N-1:0] er;
    logic [DW-1:0]   bn;
  } exp_t;

  logic            clk = 0;
  logic            rst = 1;
  logic            start = 0;
  logic [DW*N-1:0] inp = '0;
  logic [DW*N-1:0] w = '0;
  logic [DW-1:0]   bias = '0;
  logic [DW-1:0]   delta = '0;
  logic            busy, done;
  logic [DW*N-1:0] w_new, err_out;
  logic [DW-1:0]   bias_new;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;

  neuron_backprop_update #(.N(N), .DW(DW), .LR_SHIFT(LR)) dut (
    .clk(clk), .rst(rst), .start(start), .inp(inp), .w(w), .bias(bias), .delta(delta),
    .busy(busy), .done(done), .w_new(w_new), .bias_new(bias_new), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW*N-1:0] got, input logic [DW*N-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int floor_div(input int p, input int s);
    int d;
    d = 1 << s;
    return (p >= 0) ? p / d : -((-p + d - 1) / d);
  endfunction

  function automatic int clamp(input int x);
    return (x > 127) ? 127 : (x < -128) ? -128 : x;
  endfunction

  function automatic int sv8(input logic [DW-1:0] x);
    logic signed [DW-1:0] t;
    t = x;
    return int'(t);
  endfunction

  function automatic exp_t model(input logic [DW*N-1:0] a_inp, input logic [DW*N-1:0] a_w,
                                 input logic [DW-1:0] a_b, input logic [DW-1:0] a_d);
    exp_t e;
    int xi, wi, d, v;
    d = sv8(a_d);
    for (int i = 0; i < N; i++) begin
      xi = sv8(a_inp[DW*i +: DW]);
      wi = sv8(a_w[DW*i +: DW]);
      v = clamp(wi - floor_div(xi * d, 7 + LR));
      e.wn[DW*i +: DW] = v[DW-1:0];
      v = clamp(floor_div(wi * d, 7));
      e.er[DW*i +: DW] = v[DW-1:0];
    end
    v = clamp(sv8(a_b) - floor_div(d, LR));
    e.bn = v[DW-1:0];
    return e;
  endfunction

  function automatic logic [DW*N-1:0] rnd_vec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW*N-1:0];
  endfunction

  function automatic logic [DW*N-1:0] fill(input logic [DW-1:0] b);
    return {N{b}};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done got done=1 expected no pending run");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < N; i++) begin
          check($sformatf("w_new[%0d]", i), (DW*N)'(w_new[DW*i +: DW]), (DW*N)'(e.wn[DW*i +: DW]));
          check($sformatf("err_out[%0d]", i), (DW*N)'(err_out[DW*i +: DW]), (DW*N)'(e.er[DW*i +: DW]));
        end
        check("bias_new", (DW*N)'(bias_new), (DW*N)'(e.bn));
      end
    end
  end

  // mode 0: plain run; 1: start pulse and operand change at edge 4; 2: start held for a back-to-back run
  task automatic do_run(input logic [DW*N-1:0] a_inp, input logic [DW*N-1:0] a_w,
                        input logic [DW-1:0] a_b, input logic [DW-1:0] a_d, input int mode,
                        input logic [DW*N-1:0] b_inp, input logic [DW*N-1:0] b_w,
                        input logic [DW-1:0] b_b, input logic [DW-1:0] b_d);
    exp_t ea, eb;
    logic eb_busy, eb_done;
    ea = model(a_inp, a_w, a_b, a_d);
    eb = model(b_inp, b_w, b_b, b_d);
    @(negedge clk);
    inp = a_inp; w = a_w; bias = a_b; delta = a_d; start = 1;
    sb.push_back(ea);
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mode != 2 && k == 0) start = 0;
      if (mode == 1 && k == 3) begin start = 1; w = b_w; inp = b_inp; delta = b_d; bias = b_b; end
      if (mode == 1 && k == 4) start = 0;
      if (mode == 2 && k == 0) begin inp = b_inp; w = b_w; bias = b_b; delta = b_d; sb.push_back(eb); end
      if (mode == 2 && k == 12) begin
        start = 0;
        check("hold_w_new", w_new, ea.wn);
        check("hold_err_out", err_out, ea.er);
      end
      eb_busy = (k <= 10) || (mode == 2 && k >= 12 && k <= 22);
      eb_done = (k == 11) || (mode == 2 && k == 23);
      check($sformatf("busy@%0d", k), (DW*N)'(busy), (DW*N)'(eb_busy));
      check($sformatf("done@%0d", k), (DW*N)'(done), (DW*N)'(eb_done));
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    inp = rnd_vec(); w = rnd_vec(); bias = 8'($urandom); delta = 8'($urandom); start = 1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) start = 0;
    end
    #2 rst = 1;
    #1;
    check("rst_busy", (DW*N)'(busy), '0);
    check("rst_done", (DW*N)'(done), '0);
    check("rst_w_new", w_new, '0);
    check("rst_err_out", err_out, '0);
    check("rst_bias_new", (DW*N)'(bias_new), '0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    logic [DW*N-1:0] si, sw;
    #3;
    check("init_busy", (DW*N)'(busy), '0);
    check("init_done", (DW*N)'(done), '0);
    check("init_w_new", w_new, '0);
    check("init_err_out", err_out, '0);
    check("init_bias_new", (DW*N)'(bias_new), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    do_run(fill(8'h40), fill(8'h20), 8'h10, 8'h40, 0, '0, '0, '0, '0);
    check("nominal_w_new", w_new, fill(8'h1C));
    check("nominal_err_out", err_out, fill(8'h10));
    check("nominal_bias_new", (DW*N)'(bias_new), (DW*N)'(8'h08));
    si = rnd_vec(); sw = rnd_vec();
    si[15:0] = 16'h807F;
    sw[15:0] = 16'h7F80;
    do_run(si, sw, 8'h80, 8'h7F, 0, '0, '0, '0, '0);
    check("sat_w0", (DW*N)'(w_new[7:0]), (DW*N)'(8'h80));
    check("sat_w1", (DW*N)'(w_new[15:8]), (DW*N)'(8'h7F));
    check("sat_err0", (DW*N)'(err_out[7:0]), (DW*N)'(8'h81));
    check("sat_bias", (DW*N)'(bias_new), (DW*N)'(8'h80));
    do_run(fill(8'h01), '0, 8'h20, 8'hFF, 0, '0, '0, '0, '0);
    check("floor_w_new", w_new, fill(8'h01));
    check("floor_err_out", err_out, '0);
    check("floor_bias", (DW*N)'(bias_new), (DW*N)'(8'h21));
    do_run(rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom), 1,
           rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom));
    reset_mid_run();
    do_run(rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom), 0, '0, '0, '0, '0);
    do_run(rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom), 2,
           rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom));
    for (int r = 0; r < 25; r++)
      do_run(rnd_vec(), rnd_vec(), 8'($urandom), 8'($urandom), 0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", (DW*N)'(sb.size()), '0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
